// File: rtl/greg_sb.sv
// General-register file with N combinational read ports, optional write-to-read
// bypass and a per-register pending-write scoreboard for issue hazard stalls.
module greg_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_wr,
    input  logic [ADDR_W-1:0]        wr_num,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NREAD*ADDR_W-1:0]  rd_num,
    output logic [NREAD*DATA_W-1:0]  rd_data,
    output logic [NREAD-1:0]         rd_busy,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_num
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy;
    logic              wr_en;
    logic              set_en;

    // Register 0 is hardwired: never written, never marked pending.
    assign wr_en  = reg_wr && (wr_num != '0);
    assign set_en = busy_set && (busy_num != '0);

    // Storage and scoreboard; the set is issued after the clear so a newer producer wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_num]  <= wr_data;
                busy[wr_num] <= 1'b0;
            end
            if (set_en) begin
                busy[busy_num] <= 1'b1;
            end
        end
    end

    // Zero-latency read ports, each with its own bypass compare.
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              hit;
        logic              zero;

        assign idx  = rd_num[k*ADDR_W +: ADDR_W];
        assign zero = rst || (idx == '0);
        assign hit  = (BYPASS == 1) && wr_en && (wr_num == idx);

        assign rd_data[k*DATA_W +: DATA_W] = zero ? '0 : (hit ? wr_data : mem[idx]);
        assign rd_busy[k] = !zero && !hit && busy[idx];
    end

endmodule

// File: tb/tb_greg_sb.sv
// Scoreboard bench for greg_sb: a 4-port bypassing instance and a 2-port
// non-bypassing instance share write/issue stimulus and are checked against a model.
module tb_greg_sb;

    logic         clk;
    logic         rst;
    logic         reg_wr;
    logic [4:0]   wr_num;
    logic [31:0]  wr_data;
    logic [19:0]  rd_num;
    logic         busy_set;
    logic [4:0]   busy_num;
    logic [127:0] rd_data_a;
    logic [3:0]   rd_busy_a;
    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;

    greg_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(4), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .reg_wr(reg_wr), .wr_num(wr_num), .wr_data(wr_data),
        .rd_num(rd_num), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .busy_set(busy_set), .busy_num(busy_num)
    );

    greg_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .reg_wr(reg_wr), .wr_num(wr_num), .wr_data(wr_data),
        .rd_num(rd_num[9:0]), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .busy_set(busy_set), .busy_num(busy_num)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [127:0] da;
        logic [3:0]   ba;
        logic [63:0]  db;
        logic [1:0]   bb;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model_mem [32];
    logic [31:0] model_busy;
    int          total = 0;
    int          bad   = 0;

    logic [127:0] obs_da;
    logic [3:0]   obs_ba;
    logic [63:0]  obs_db;
    logic [1:0]   obs_bb;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t calc();
        exp_t e;
        logic [4:0] idx;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            idx = rd_num[k*5 +: 5];
            if (!rst && idx != 5'd0) begin
                if (reg_wr && wr_num == idx) begin
                    e.da[k*32 +: 32] = wr_data;
                    e.ba[k] = 1'b0;
                end else begin
                    e.da[k*32 +: 32] = model_mem[idx];
                    e.ba[k] = model_busy[idx];
                end
                if (k < 2) begin
                    e.db[k*32 +: 32] = model_mem[idx];
                    e.bb[k] = model_busy[idx];
                end
            end
        end
        return e;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
            model_busy = 32'd0;
        end else begin
            if (reg_wr && wr_num != 5'd0) begin
                model_mem[wr_num] = wr_data;
                model_busy[wr_num] = 1'b0;
            end
            if (busy_set && busy_num != 5'd0) model_busy[busy_num] = 1'b1;
        end
    endtask

    // One cycle: drive, predict, sample mid-cycle, compare, advance the model at the edge.
    task automatic step(input logic rs, input logic w, input logic [4:0] wn, input logic [31:0] wd,
                        input logic bs, input logic [4:0] bn, input logic [19:0] rn);
        exp_t e;
        rst = rs; reg_wr = w; wr_num = wn; wr_data = wd;
        busy_set = bs; busy_num = bn; rd_num = rn;
        sbq.push_back(calc());
        #3;
        obs_da = rd_data_a; obs_ba = rd_busy_a; obs_db = rd_data_b; obs_bb = rd_busy_b;
        e = sbq.pop_front();
        check_val("data_byp",   obs_da, e.da);
        check_val("busy_byp",   128'(obs_ba), 128'(e.ba));
        check_val("data_nobyp", 128'(obs_db), 128'(e.db));
        check_val("busy_nobyp", 128'(obs_bb), 128'(e.bb));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic [19:0] rn);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, rn);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
        model_busy = 32'd0;
        #1;
        // Reset, then r5 write cleared by a later reset
        step(1'b1, 1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, {5'd5, 5'd5, 5'd5, 5'd5});
        check_val("rst_data_zero", obs_da, 128'd0);
        step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 20'd0);
        idle({15'd0, 5'd5});
        check_val("r5_written", 128'(obs_da[31:0]), 128'(32'h1234));
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd5, 5'd5, 5'd5, 5'd5});
        check_val("rst_cycle_data", obs_da, 128'd0);
        idle({15'd0, 5'd5});
        check_val("r5_after_rst", 128'(obs_da[31:0]), 128'd0);
        check_val("r5_busy_after_rst", 128'(obs_ba[0]), 128'd0);

        // Bypass versus non-bypass on r3
        step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, {15'd0, 5'd3});
        check_val("byp_same_cycle", 128'(obs_da[31:0]), 128'(32'hDEADBEEF));
        check_val("nobyp_old_value", 128'(obs_db[31:0]), 128'd0);
        idle({15'd0, 5'd3});
        check_val("byp_next_cycle", 128'(obs_da[31:0]), 128'(32'hDEADBEEF));
        check_val("nobyp_next_cycle", 128'(obs_db[31:0]), 128'(32'hDEADBEEF));

        // Register zero
        step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 20'd0);
        check_val("r0_write_cycle", obs_da, 128'd0);
        idle(20'd0);
        check_val("r0_data", obs_da, 128'd0);
        check_val("r0_busy", 128'(obs_ba), 128'd0);

        // Scoreboard on r7
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, {15'd0, 5'd7});
        check_val("r7_busy_set_cycle", 128'(obs_ba[0]), 128'd0);
        idle({15'd0, 5'd7});
        check_val("r7_busy_n1", 128'(obs_ba[0]), 128'd1);
        idle({15'd0, 5'd7});
        step(1'b0, 1'b1, 5'd7, 32'h70, 1'b0, 5'd0, {15'd0, 5'd7});
        check_val("r7_busy_wr_byp", 128'(obs_ba[0]), 128'd0);
        check_val("r7_busy_wr_nobyp", 128'(obs_bb[0]), 128'd1);
        idle({15'd0, 5'd7});
        check_val("r7_busy_n4", 128'({obs_ba[0], obs_bb[0]}), 128'd0);
        step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, {15'd0, 5'd7});
        idle({15'd0, 5'd7});
        check_val("r7_set_wins", 128'(obs_ba[0]), 128'd1);
        check_val("r7_data_upd", 128'(obs_da[31:0]), 128'(32'h77));

        // Multi-port reads with independent busy bits
        step(1'b0, 1'b1, 5'd1, 32'd1, 1'b0, 5'd0, 20'd0);
        step(1'b0, 1'b1, 5'd2, 32'd2, 1'b1, 5'd2, 20'd0);
        step(1'b0, 1'b1, 5'd31, 32'h1F, 1'b0, 5'd0, {5'd31, 5'd1, 5'd2, 5'd1});
        idle({5'd31, 5'd1, 5'd2, 5'd1});
        check_val("mp_data", obs_da, {32'h1F, 32'd1, 32'd2, 32'd1});
        check_val("mp_busy", 128'(obs_ba), 128'(4'b0010));

        // Random traffic with occasional mid-stream reset
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 29) == 0), 1'($urandom), 5'($urandom), $urandom,
                 1'($urandom), 5'($urandom), 20'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
